sram_like_arbiter: RTL and testbench

Downstream of the CPU core's instruction and data SRAM-style ports. Arbitrates the inst and data masters onto one shared memory request/response channel with variable latency. Returns each master an address-accept pulse and a data-complete pulse. Supports one outstanding transaction at a time, so the core can later run against slow, off-core memory instead of single-cycle SRAM.

---
 rtl/sram_like_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto a single variable-latency memory channel.
// One transaction is in flight at a time. Ties alternate between masters, and
// the first tie after reset goes to data.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction master
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // shared memory channel
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [3:0]        mem_req_wstrb,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic {M_INST = 1'b0, M_DATA = 1'b1} master_t;

  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t   state;
  master_t  owner;
  master_t  last_grant;
  mem_req_t req_q;
  mem_req_t req_sel;
  logic     grant_inst;
  logic     grant_data;

  // Pick a winner: a lone requester wins, a tie goes opposite the last grant
  always_comb begin
    grant_data = data_req & (~inst_req | (last_grant == M_INST));
    grant_inst = inst_req & (~data_req | (last_grant == M_DATA));
  end

  // Accept pulses are combinational so a master sees acceptance in its request
  // cycle; gated by resetn so nothing looks accepted while reset is applied.
  assign inst_addr_ok = resetn & (state == IDLE) & grant_inst;
  assign data_addr_ok = resetn & (state == IDLE) & grant_data;

  // Build the request the winner would launch; inst is always a plain read,
  // and strobes are zeroed for any read.
  always_comb begin
    req_sel = '0;
    if (grant_data) begin
      req_sel.wr    = data_wr;
      req_sel.wstrb = data_wr ? data_wstrb : 4'h0;
      req_sel.addr  = data_addr;
      req_sel.wdata = data_wdata;
    end else begin
      req_sel.addr  = inst_addr;
    end
  end

  // Transaction FSM with all channel and completion outputs registered
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      owner         <= M_INST;
      last_grant    <= M_INST;
      req_q         <= '0;
      mem_req_valid <= 1'b0;
      inst_data_ok  <= 1'b0;
      data_data_ok  <= 1'b0;
      inst_rdata    <= '0;
      data_rdata    <= '0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_inst | grant_data) begin
            owner         <= grant_data ? M_DATA : M_INST;
            last_grant    <= grant_data ? M_DATA : M_INST;
            req_q         <= req_sel;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // request fields in req_q are held untouched until the handshake
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // responses outside WAIT (e.g. stale ones after reset) never land here
          if (mem_resp_valid) begin
            if (owner == M_DATA) begin
              data_rdata   <= mem_resp_rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= mem_resp_rdata;
              inst_data_ok <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_wr    = req_q.wr;
  assign mem_req_wstrb = req_q.wstrb;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + randomized bench for sram_like_arbiter. A transaction-level model
// predicts the winner of each arbitration, the request launched on the memory
// channel and the read data each master should hold.
module tb_sram_like_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic          data_wr = 1'b0;
  logic [3:0]    data_wstrb = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_wr;
  logic [3:0]    mem_req_wstrb;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            ref_last_data;   // last grant went to data
  logic [DW-1:0] ref_inst_rdata;
  logic [DW-1:0] ref_data_rdata;
  int            grant_log[$];    // 0 = inst, 1 = data, in grant order

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic model_reset();
    ref_last_data  = 1'b0;
    ref_inst_rdata = '0;
    ref_data_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, mem_req_valid, 0);
    chk({tag, "_wr"}, mem_req_wr, 0);
    chk({tag, "_wstrb"}, mem_req_wstrb, 0);
    chk({tag, "_addr"}, mem_req_addr, 0);
    chk({tag, "_wdata"}, mem_req_wdata, 0);
    chk({tag, "_dataok"}, {inst_data_ok, data_data_ok}, 0);
    chk({tag, "_irdata"}, inst_rdata, 0);
    chk({tag, "_drdata"}, data_rdata, 0);
  endtask

  // Run one full transaction; the DUT is expected idle with >=1 request driven.
  task automatic serve(input bit keep, input int rdy_dly, input int rsp_dly,
                       input bit stale_req, input logic [DW-1:0] rd);
    bit            exp_data;
    logic [AW-1:0] ea;
    logic          ewr;
    logic [3:0]    es;
    logic [DW-1:0] ed;

    exp_data = (inst_req && data_req) ? !ref_last_data : data_req;
    ea  = exp_data ? data_addr : inst_addr;
    ewr = exp_data ? data_wr : 1'b0;
    es  = (exp_data && data_wr) ? data_wstrb : 4'h0;
    ed  = data_wdata;

    sample();
    chk("grant_inst", inst_addr_ok, !exp_data);
    chk("grant_data", data_addr_ok, exp_data);
    chk("idle_no_dataok", {inst_data_ok, data_data_ok}, 0);
    chk("idle_irdata", inst_rdata, ref_inst_rdata);
    chk("idle_drdata", data_rdata, ref_data_rdata);
    ref_last_data = exp_data;
    grant_log.push_back(int'(exp_data));
    step();

    // winner is free to move on to its next request
    if (exp_data) begin
      if (!keep) data_req = 1'b0;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_wr    = 1'($urandom);
      data_wstrb = 4'($urandom);
    end else begin
      if (!keep) inst_req = 1'b0;
      inst_addr = $urandom;
    end

    for (int i = 0; i <= rdy_dly; i++) begin
      mem_req_ready  = (i == rdy_dly);
      mem_resp_valid = stale_req && (i == 0);
      mem_resp_rdata = $urandom;
      sample();
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, ea);
      chk("req_wr", mem_req_wr, ewr);
      chk("req_wstrb", mem_req_wstrb, es);
      if (exp_data) chk("req_wdata", mem_req_wdata, ed);
      chk("req_no_addrok", {inst_addr_ok, data_addr_ok}, 0);
      chk("req_no_dataok", {inst_data_ok, data_data_ok}, 0);
      step();
    end

    mem_req_ready = 1'b0;
    for (int i = 0; i <= rsp_dly; i++) begin
      mem_resp_valid = (i == rsp_dly);
      mem_resp_rdata = (i == rsp_dly) ? rd : DW'($urandom);
      sample();
      chk("wait_valid_low", mem_req_valid, 0);
      chk("wait_no_addrok", {inst_addr_ok, data_addr_ok}, 0);
      chk("wait_no_dataok", {inst_data_ok, data_data_ok}, 0);
      step();
    end
    mem_resp_valid = 1'b0;
    if (exp_data) ref_data_rdata = rd; else ref_inst_rdata = rd;

    sample();
    chk("done_inst_ok", inst_data_ok, !exp_data);
    chk("done_data_ok", data_data_ok, exp_data);
    chk("done_irdata", inst_rdata, ref_inst_rdata);
    chk("done_drdata", data_rdata, ref_data_rdata);
    chk("done_no_addrok", {inst_addr_ok, data_addr_ok}, 0);
    step();
  endtask

  initial begin
    model_reset();
    // reset with no requests
    step();
    step();
    resetn = 1'b1;
    sample();
    check_reset_outputs("reset");
    chk("reset_addrok", {inst_addr_ok, data_addr_ok}, 0);
    step();

    // single inst read, minimum latency
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    serve(1'b0, 0, 0, 1'b0, 32'h2408_0001);

    // data write with a slow-ready memory
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_1000;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    serve(1'b0, 3, int'($urandom_range(2, 0)), 1'b0, $urandom);

    // stale response while idle is ignored
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    sample();
    chk("stale_idle_addrok", {inst_addr_ok, data_addr_ok}, 0);
    step();
    mem_resp_valid = 1'b0;
    sample();
    chk("stale_idle_dataok", {inst_data_ok, data_data_ok}, 0);
    chk("stale_idle_drdata", data_rdata, ref_data_rdata);
    step();

    // data read with a stale response pulsed during REQ
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0004; data_wstrb = 4'hF;
    serve(1'b0, 2, 1, 1'b1, 32'h1234_5678);
    // inst read must leave data_rdata alone
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    serve(1'b0, 0, 0, 1'b0, 32'h0000_0000);
    chk("data_rdata_kept", data_rdata, 32'h1234_5678);

    // reset while WAIT: transaction aborted, late response ignored
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    sample();
    chk("rst_grant", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; mem_req_ready = 1'b1;
    sample();
    chk("rst_req_valid", mem_req_valid, 1);
    step();
    mem_req_ready = 1'b0;
    sample();
    chk("rst_wait_valid", mem_req_valid, 0);
    step();
    resetn = 1'b0;
    sample();
    step();
    resetn = 1'b1;
    model_reset();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    sample();
    check_reset_outputs("rst_wait");
    step();
    mem_resp_valid = 1'b0;
    sample();
    chk("rst_late_dataok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_late_irdata", inst_rdata, 0);
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    serve(1'b0, 0, 0, 1'b0, $urandom);

    // both masters held high from reset: grants alternate starting with data
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    model_reset();
    grant_log.delete();
    for (int k = 0; k < 4; k++) serve(1'b1, 0, 0, 1'b0, $urandom);
    chk("alt_count", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size(); k++)
      chk("alt_order", grant_log[k], (k % 2 == 0) ? 1 : 0);

    // randomized traffic; pending requests are held until accepted
    inst_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!inst_req) begin inst_req = 1'($urandom); inst_addr = $urandom; end
      if (!data_req) begin
        data_req = 1'($urandom); data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom); data_wstrb = 4'($urandom);
      end
      if (!inst_req && !data_req) inst_req = 1'b1;
      serve(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            1'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
